// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: acquires lock on the P/Pr marker pair, tracks frame position
// and steers each data bit into the timestamp accumulator, flushing on frame errors.
module irig_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym_type,
  output logic [2:0] ts_select,
  output logic [4:0] bit_idx,
  output logic [1:0] digit_idx,
  output logic       bit_value,
  output logic       ts_finish,
  output logic       ts_valid,
  output logic       locked,
  output logic       frame_err,
  output logic [6:0] frame_pos
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [6:0]    pos_s, pos_nx_s;
  logic [2:0]    sel_s;
  logic [1:0]    dig_s;
  logic [4:0]    bit_s;
  logic          bv_s, fin_s, valid_s, err_s, flush_s;
  logic          is_mark_s, mark_slot_s, slot_ok_s, timeout_s;
  logic [9:0]    fmap_s;

  // Returns {select, digit, bit} for a frame position; unmapped positions give zero.
  function automatic logic [9:0] field_map(input logic [6:0] p);
    logic [2:0] sel;
    logic [1:0] dig;
    logic [6:0] base;
    sel = 3'd0; dig = 2'd0; base = p;
    if (p >= 7'd1 && p <= 7'd4) begin sel = 3'd1; dig = 2'd0; base = 7'd1; end
    else if (p >= 7'd6  && p <= 7'd8)  begin sel = 3'd1; dig = 2'd1; base = 7'd6;  end
    else if (p >= 7'd10 && p <= 7'd13) begin sel = 3'd2; dig = 2'd0; base = 7'd10; end
    else if (p >= 7'd15 && p <= 7'd17) begin sel = 3'd2; dig = 2'd1; base = 7'd15; end
    else if (p >= 7'd20 && p <= 7'd23) begin sel = 3'd3; dig = 2'd0; base = 7'd20; end
    else if (p >= 7'd25 && p <= 7'd26) begin sel = 3'd3; dig = 2'd1; base = 7'd25; end
    else if (p >= 7'd30 && p <= 7'd33) begin sel = 3'd4; dig = 2'd0; base = 7'd30; end
    else if (p >= 7'd35 && p <= 7'd38) begin sel = 3'd4; dig = 2'd1; base = 7'd35; end
    else if (p >= 7'd40 && p <= 7'd41) begin sel = 3'd4; dig = 2'd2; base = 7'd40; end
    else if (p >= 7'd50 && p <= 7'd53) begin sel = 3'd5; dig = 2'd0; base = 7'd50; end
    else if (p >= 7'd55 && p <= 7'd58) begin sel = 3'd5; dig = 2'd1; base = 7'd55; end
    else if (p >= 7'd80 && p <= 7'd88) begin sel = 3'd6; dig = 2'd0; base = 7'd80; end
    // sec_day continues past the P8 marker at 89, so bit 9 sits at position 90
    else if (p >= 7'd90 && p <= 7'd97) begin sel = 3'd6; dig = 2'd0; base = 7'd81; end
    else begin sel = 3'd0; dig = 2'd0; base = p; end
    return {sel, dig, 5'(p - base)};
  endfunction

  assign is_mark_s   = (sym_type == 2'd2);
  assign pos_nx_s    = (frame_pos == 7'd99) ? 7'd0 : frame_pos + 7'd1;
  assign mark_slot_s = (pos_nx_s == 7'd0) || ((pos_nx_s % 7'd10) == 7'd9);
  assign slot_ok_s   = mark_slot_s ? is_mark_s : !sym_type[1];
  assign timeout_s   = !sym_valid && (state_r != HUNT) && (timer_r == TIMER_LAST);
  assign fmap_s      = field_map(pos_nx_s);

  // Next-state, timer and next-output decode.
  always_comb begin
    state_s = state_r;
    pos_s   = frame_pos;
    sel_s   = 3'd0;
    dig_s   = 2'd0;
    bit_s   = 5'd0;
    bv_s    = 1'b0;
    fin_s   = 1'b0;
    err_s   = 1'b0;
    valid_s = ts_valid;
    flush_s = 1'b0;
    if (sym_valid) begin
      timer_s = {TW{1'b0}};
    end else if (state_r != HUNT && timer_r != TIMER_LAST) begin
      timer_s = timer_r + TW'(1);
    end else begin
      timer_s = timer_r;
    end
    case (state_r)
      HUNT: begin
        if (sym_valid && is_mark_s) state_s = SYNC;
        else state_s = HUNT;
      end
      SYNC: begin
        if (sym_valid) begin
          if (is_mark_s) begin
            state_s = LOCKED;
            pos_s   = 7'd0;
          end else begin
            state_s = HUNT;
          end
        end else if (timeout_s) begin
          state_s = HUNT;
        end else begin
          state_s = SYNC;
        end
      end
      LOCKED: begin
        if (sym_valid) begin
          if (slot_ok_s) begin
            pos_s                 = pos_nx_s;
            {sel_s, dig_s, bit_s} = fmap_s;
            bv_s                  = sym_type[0] && (fmap_s[9:7] != 3'd0);
            if (pos_nx_s == 7'd99) begin
              fin_s   = 1'b1;
              valid_s = 1'b1;
            end else begin
              fin_s = 1'b0;
            end
          end else begin
            flush_s = 1'b1;
          end
        end else if (timeout_s) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      default: begin
        state_s = HUNT;
        pos_s   = 7'd0;
      end
    endcase
    if (flush_s) begin
      state_s = HUNT;
      pos_s   = 7'd0;
      err_s   = 1'b1;
      fin_s   = 1'b1;
      valid_s = 1'b0;
    end else begin
      err_s = 1'b0;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HUNT;
      timer_r   <= {TW{1'b0}};
      frame_pos <= 7'd0;
      locked    <= 1'b0;
      ts_select <= 3'd0;
      digit_idx <= 2'd0;
      bit_idx   <= 5'd0;
      bit_value <= 1'b0;
      ts_finish <= 1'b0;
      ts_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      frame_pos <= pos_s;
      locked    <= (state_s == LOCKED);
      ts_select <= sel_s;
      digit_idx <= dig_s;
      bit_idx   <= bit_s;
      bit_value <= bv_s;
      ts_finish <= fin_s;
      ts_valid  <= valid_s;
      frame_err <= err_s;
    end
  end

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Bench for irig_frame_sequencer: frame-level model with accumulator, per-cycle compare,
// and directed scenarios for lock, violations, timeout, async reset and recovery.
module tb_irig_frame_sequencer;

  localparam int T = 40;
  localparam int ZERO = 0, ONE = 1, MARK = 2, ERR = 3;

  logic       clk, rst_n, sym_valid;
  logic [1:0] sym_type;
  logic [2:0] ts_select;
  logic [4:0] bit_idx;
  logic [1:0] digit_idx;
  logic       bit_value, ts_finish, ts_valid, locked, frame_err;
  logic [6:0] frame_pos;

  irig_frame_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_type(sym_type),
    .ts_select(ts_select), .bit_idx(bit_idx), .digit_idx(digit_idx),
    .bit_value(bit_value), .ts_finish(ts_finish), .ts_valid(ts_valid),
    .locked(locked), .frame_err(frame_err), .frame_pos(frame_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  // Field layout as (start, length, select, digit) plus the split sec_day run.
  int f_start[11] = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
  int f_len[11]   = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};
  int f_sel[11]   = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5};
  int f_dig[11]   = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 1};
  int tbl_sel[100], tbl_dig[100], tbl_bit[100];
  int frame_sym[100];
  int vals[7] = '{0, 56, 34, 12, 123, 24, 45296};

  // Model state
  int phase, pos, idle;
  int e_sel, e_dig, e_bit, e_bv, e_fin, e_err, e_val, e_lock, e_pos;
  int m_acc[7], m_res[7], d_acc[7], d_res[7];

  function automatic int pw10(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 10 : 100);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic build();
    int b;
    for (int p = 0; p < 100; p++) begin tbl_sel[p] = 0; tbl_dig[p] = 0; tbl_bit[p] = 0; end
    for (int i = 0; i < 11; i++)
      for (int k = 0; k < f_len[i]; k++) begin
        tbl_sel[f_start[i]+k] = f_sel[i];
        tbl_dig[f_start[i]+k] = f_dig[i];
        tbl_bit[f_start[i]+k] = k;
      end
    b = 0;
    for (int p = 80; p <= 97; p++)
      if (p != 89) begin tbl_sel[p] = 6; tbl_bit[p] = b; b++; end
    for (int p = 0; p < 100; p++) begin
      if (p == 0 || p % 10 == 9) frame_sym[p] = MARK;
      else if (tbl_sel[p] == 0) frame_sym[p] = ZERO;
      else if (tbl_sel[p] == 6) frame_sym[p] = (vals[6] >> tbl_bit[p]) & 1;
      else frame_sym[p] = ((vals[tbl_sel[p]] / pw10(tbl_dig[p])) % 10 >> tbl_bit[p]) & 1;
    end
  endtask

  task automatic model_reset();
    phase = 0; pos = 0; idle = 0;
    e_sel = 0; e_dig = 0; e_bit = 0; e_bv = 0; e_fin = 0; e_err = 0;
    e_val = 0; e_lock = 0; e_pos = 0;
    for (int i = 0; i < 7; i++) m_acc[i] = 0;
  endtask

  task automatic latch_sums();
    for (int i = 0; i < 7; i++) begin m_res[i] = m_acc[i]; m_acc[i] = 0; end
  endtask

  task automatic flush();
    phase = 0; pos = 0; e_fin = 1; e_err = 1; e_val = 0;
    latch_sums();
  endtask

  task automatic model_step(input bit v, input int t);
    int q;
    bit ok;
    e_sel = 0; e_dig = 0; e_bit = 0; e_bv = 0; e_fin = 0; e_err = 0;
    if (v) begin
      idle = 0;
      if (phase == 0) begin
        if (t == MARK) phase = 1;
      end else if (phase == 1) begin
        if (t == MARK) begin phase = 2; pos = 0; end
        else phase = 0;
      end else begin
        q = (pos + 1) % 100;
        ok = (q == 0 || q % 10 == 9) ? (t == MARK) : (t == ZERO || t == ONE);
        if (!ok) flush();
        else begin
          pos = q;
          if (tbl_sel[q] != 0) begin
            e_sel = tbl_sel[q]; e_dig = tbl_dig[q]; e_bit = tbl_bit[q];
            e_bv = (t == ONE) ? 1 : 0;
            if (t == ONE) begin
              if (e_sel == 6) m_acc[6] += (1 << e_bit);
              else m_acc[e_sel] += (1 << e_bit) * pw10(e_dig);
            end
          end
          if (q == 99) begin e_fin = 1; e_val = 1; latch_sums(); end
        end
      end
    end else if (phase != 0) begin
      idle++;
      if (idle >= T) begin
        if (phase == 1) phase = 0;
        else flush();
      end
    end
    e_lock = (phase == 2) ? 1 : 0;
    e_pos = (phase == 2) ? pos : 0;
  endtask

  task automatic cyc(input bit v, input int t);
    sym_valid = v;
    sym_type = 2'(t);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, t);
    #1;
  endtask

  task automatic sym(input int t);
    cyc(1'b1, t); cyc(1'b0, 0); cyc(1'b0, 0);
  endtask

  task automatic send_range(input int a, input int b);
    for (int p = a; p <= b; p++) sym(frame_sym[p]);
  endtask

  // Per-cycle compare against the model, plus an accumulator fed by DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 7; i++) d_acc[i] = 0;
      end else begin
        if (ts_select != 3'd0 && ts_select <= 3'd6 && bit_value) begin
          if (ts_select == 3'd6) d_acc[6] += (1 << bit_idx);
          else d_acc[ts_select] += (1 << bit_idx) * pw10(int'(digit_idx));
        end
        if (ts_finish)
          for (int i = 0; i < 7; i++) begin d_res[i] = d_acc[i]; d_acc[i] = 0; end
      end
      chk("ts_select", int'(ts_select), e_sel);
      chk("bit_value", int'(bit_value), e_bv);
      chk("ts_finish", int'(ts_finish), e_fin);
      chk("frame_err", int'(frame_err), e_err);
      chk("ts_valid", int'(ts_valid), e_val);
      chk("locked", int'(locked), e_lock);
      chk("frame_pos", int'(frame_pos), e_pos);
      if (e_sel != 0) begin
        chk("digit_idx", int'(digit_idx), e_dig);
        chk("bit_idx", int'(bit_idx), e_bit);
      end
    end
  end

  initial begin
    for (int i = 0; i < 7; i++) begin d_res[i] = 0; m_res[i] = 0; d_acc[i] = 0; end
    build();
    rst_n = 1'b0; sym_valid = 1'b0; sym_type = 2'd0;
    model_reset();
    repeat (3) cyc(1'b0, 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pos", int'(frame_pos), 0);
    chk("rst_valid", int'(ts_valid), 0);
    rst_n = 1'b1;

    // Two clean frames after P,Pr
    sym(MARK); sym(MARK);
    chk("t1_locked", int'(locked), 1);
    send_range(1, 99);
    send_range(0, 98);
    cyc(1'b1, MARK);
    chk("t1_finish", int'(ts_finish), 1);
    chk("t1_valid", int'(ts_valid), 1);
    cyc(1'b0, 0); cyc(1'b0, 0);
    chk("t1_finish_end", int'(ts_finish), 0);
    chk("t1_sec", d_res[1], 56);
    chk("t1_min", d_res[2], 34);
    chk("t1_hour", d_res[3], 12);
    chk("t1_day", d_res[4], 123);
    chk("t1_year", d_res[5], 24);
    chk("t1_sbs", d_res[6], 45296);
    chk("model_sec", m_res[1], 56);
    chk("model_day", m_res[4], 123);
    chk("model_sbs", m_res[6], 45296);

    // ONE where the P4 marker belongs
    send_range(0, 48);
    cyc(1'b1, ONE);
    chk("t3_err", int'(frame_err), 1);
    chk("t3_finish", int'(ts_finish), 1);
    chk("t3_valid", int'(ts_valid), 0);
    chk("t3_locked", int'(locked), 0);
    cyc(1'b0, 0); cyc(1'b0, 0);
    chk("t3_err_end", int'(frame_err), 0);

    // Lock acquisition needs two consecutive MARKs
    sym(ZERO); sym(ONE); sym(MARK); sym(ONE); sym(MARK);
    chk("t2_not_locked", int'(locked), 0);
    cyc(1'b1, MARK);
    chk("t2_locked", int'(locked), 1);
    chk("t2_pos0", int'(frame_pos), 0);
    cyc(1'b0, 0); cyc(1'b0, 0);
    cyc(1'b1, ONE);
    chk("t2_sel", int'(ts_select), 1);
    chk("t2_digit", int'(digit_idx), 0);
    chk("t2_bit", int'(bit_idx), 0);
    chk("t2_bv", int'(bit_value), 1);
    cyc(1'b0, 0);
    chk("t2_sel_end", int'(ts_select), 0);
    cyc(1'b0, 0);

    // Timeout: late symbols that still keep lock, then a real stall
    send_range(2, 40);
    repeat (T - 4) cyc(1'b0, 0);
    cyc(1'b1, frame_sym[41]);
    chk("t4_keep41", int'(locked), 1);
    repeat (T - 1) cyc(1'b0, 0);
    cyc(1'b1, frame_sym[42]);
    chk("t4_keep42", int'(locked), 1);
    chk("t4_pos42", int'(frame_pos), 42);
    repeat (T - 1) cyc(1'b0, 0);
    chk("t4_pre_locked", int'(locked), 1);
    chk("t4_pre_err", int'(frame_err), 0);
    cyc(1'b0, 0);
    chk("t4_err", int'(frame_err), 1);
    chk("t4_finish", int'(ts_finish), 1);
    chk("t4_locked", int'(locked), 0);
    cyc(1'b0, 0);

    // Async reset mid-frame
    sym(MARK); sym(MARK);
    send_range(1, 55);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_locked", int'(locked), 0);
    chk("t5_pos", int'(frame_pos), 0);
    chk("t5_sel", int'(ts_select), 0);
    chk("t5_valid", int'(ts_valid), 0);
    model_reset();
    repeat (3) cyc(1'b0, 0);
    rst_n = 1'b1;
    sym(MARK);
    chk("t5_one_mark", int'(locked), 0);
    sym(MARK);
    chk("t5_relock", int'(locked), 1);

    // ERROR symbol flushes, next clean frame recovers
    send_range(1, 99);
    chk("t6_valid_pre", int'(ts_valid), 1);
    send_range(0, 84);
    cyc(1'b1, ERR);
    chk("t6_err", int'(frame_err), 1);
    chk("t6_valid", int'(ts_valid), 0);
    cyc(1'b0, 0); cyc(1'b0, 0);
    sym(MARK); sym(MARK);
    send_range(1, 99);
    chk("t6_valid_post", int'(ts_valid), 1);
    chk("t6_sbs", d_res[6], 45296);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
